zig_zag_reorder_buffer: RTL and testbench
=========================================

ZIG_ZAG_REORDER_BUFFER -- requirements
Module: zig_zag_reorder_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 12, is the width of each coefficient word.
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_data  input  DATA_WIDTH  coefficient, presented in zig-zag scan order.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  the buffer accepts in_data this cycle.
REQ-007 out_data  output  DATA_WIDTH  coefficient, emitted in row-major order.
REQ-008 out_index  output  6  row-major index (row*8+col) of out_data.
REQ-009 out_last  output  1  high with the final (index 63) word of a block.
REQ-010 out_valid  output  1  out_data, out_index and out_last are valid.
REQ-011 out_ready  input  1  the downstream consumer accepts the output word this cycle.

Function
REQ-012 The block SHALL be a ping-pong buffer: two banks of 64 x DATA_WIDTH, plus a per-bank full flag.
REQ-013 An input transfer SHALL occur when in_valid and in_ready are both high; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-014 in_ready SHALL equal NOT full[wr_bank], combinationally from registered state only, with no dependence on in_valid.
REQ-015 On an input transfer, in_data SHALL be written to bank wr_bank at the row-major address of zig-zag position wr_count (standard JPEG 8x8 zig-zag), and wr_count SHALL increment.
REQ-016 On the input transfer with wr_count == 63: wr_count wraps to 0, full[wr_bank] is set, and wr_bank toggles.
REQ-017 out_valid SHALL equal full[rd_bank].
REQ-018 While out_valid is high: out_data = bank[rd_bank][rd_count], out_index = rd_count, and out_last = (rd_count == 63).
REQ-019 On an output transfer, rd_count SHALL increment; at rd_count == 63 it wraps to 0, full[rd_bank] clears, and rd_bank toggles.
REQ-020 While out_valid is high and out_ready is low, out_data, out_index and out_last SHALL hold stable.
REQ-021 Latency: the first word of a block SHALL be valid in the cycle after its 64th input transfer.
REQ-022 With out_ready held high and in_valid held high, throughput SHALL be one word per cycle sustained, and in_ready SHALL never deassert.
REQ-023 When a block completes on the write side and a different block completes on the read side in the same cycle, both SHALL take effect: one full flag sets and the other clears.
REQ-024 When both banks are full, in_ready SHALL be low until the read side completes a bank; in_ready SHALL go high in the cycle after that bank's out_last transfer.
REQ-025 Reads SHALL use only full banks; a partially written bank SHALL never be visible at the output.
REQ-026 Data SHALL pass through unmodified: no arithmetic, and no width change.

Reset
REQ-027 Reset SHALL clear wr_count, rd_count, wr_bank, rd_bank and both full flags immediately, regardless of the clock.
REQ-028 During and after reset: out_valid = 0, out_last = 0, out_index = 0 and in_ready = 1; out_data is don't-care while out_valid = 0.
REQ-029 Bank memory contents need not be reset.
REQ-030 A reset asserted mid-block SHALL discard all partial and buffered blocks; the next input transfer after reset is zig-zag position 0.

Verification
REQ-031 Feed 0..63 as in_data (data = zig-zag index) with out_ready = 1 -> 64 outputs with out_index 0..63; out_index 2 -> data 5, index 8 -> data 2, index 19 -> data 17, index 63 -> data 63; out_last only at index 63.
REQ-032 Three back-to-back blocks with in_valid and out_ready held at 1 -> in_ready stays 1 throughout; the first out_valid appears 1 cycle after the 64th input; 192 outputs arrive with no gaps.
REQ-033 out_ready = 0 with in_valid = 1 -> 128 inputs accepted, in_ready low from the cycle after the 128th; raise out_ready for 64 cycles -> in_ready returns high the cycle after the first out_last.
REQ-034 Reset after 30 inputs, then a full block of value 0x5A5 -> exactly 64 outputs, all 0x5A5; nothing from the aborted block.
REQ-035 Randomized in_valid and out_ready over 200 blocks, checked against a reference model -> row-major order is exact and no words are lost, duplicated or reordered; out_* is stable under backpressure.

Source files
------------

// File: rtl/zig_zag_reorder_buffer.sv
// Ping-pong reorder buffer: accepts 8x8 coefficient blocks in JPEG zig-zag order
// and emits them in row-major order, one bank filling while the other drains.
module zig_zag_reorder_buffer #(
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [5:0]            out_index,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    // Row-major address of a given zig-zag scan position.
    function automatic logic [5:0] zz_to_raster(input logic [5:0] pos);
        logic [5:0] addr;
        case (pos)
            6'd0:  addr = 6'd0;   6'd1:  addr = 6'd1;   6'd2:  addr = 6'd8;   6'd3:  addr = 6'd16;
            6'd4:  addr = 6'd9;   6'd5:  addr = 6'd2;   6'd6:  addr = 6'd3;   6'd7:  addr = 6'd10;
            6'd8:  addr = 6'd17;  6'd9:  addr = 6'd24;  6'd10: addr = 6'd32;  6'd11: addr = 6'd25;
            6'd12: addr = 6'd18;  6'd13: addr = 6'd11;  6'd14: addr = 6'd4;   6'd15: addr = 6'd5;
            6'd16: addr = 6'd12;  6'd17: addr = 6'd19;  6'd18: addr = 6'd26;  6'd19: addr = 6'd33;
            6'd20: addr = 6'd40;  6'd21: addr = 6'd48;  6'd22: addr = 6'd41;  6'd23: addr = 6'd34;
            6'd24: addr = 6'd27;  6'd25: addr = 6'd20;  6'd26: addr = 6'd13;  6'd27: addr = 6'd6;
            6'd28: addr = 6'd7;   6'd29: addr = 6'd14;  6'd30: addr = 6'd21;  6'd31: addr = 6'd28;
            6'd32: addr = 6'd35;  6'd33: addr = 6'd42;  6'd34: addr = 6'd49;  6'd35: addr = 6'd56;
            6'd36: addr = 6'd57;  6'd37: addr = 6'd50;  6'd38: addr = 6'd43;  6'd39: addr = 6'd36;
            6'd40: addr = 6'd29;  6'd41: addr = 6'd22;  6'd42: addr = 6'd15;  6'd43: addr = 6'd23;
            6'd44: addr = 6'd30;  6'd45: addr = 6'd37;  6'd46: addr = 6'd44;  6'd47: addr = 6'd51;
            6'd48: addr = 6'd58;  6'd49: addr = 6'd59;  6'd50: addr = 6'd52;  6'd51: addr = 6'd45;
            6'd52: addr = 6'd38;  6'd53: addr = 6'd31;  6'd54: addr = 6'd39;  6'd55: addr = 6'd46;
            6'd56: addr = 6'd53;  6'd57: addr = 6'd60;  6'd58: addr = 6'd61;  6'd59: addr = 6'd54;
            6'd60: addr = 6'd47;  6'd61: addr = 6'd55;  6'd62: addr = 6'd62;  6'd63: addr = 6'd63;
            default: addr = 6'd0;
        endcase
        return addr;
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [0:127];
    logic [5:0]            wr_count_r;
    logic [5:0]            rd_count_r;
    logic                  wr_bank_r;
    logic                  rd_bank_r;
    logic [1:0]            full_r;

    logic                  in_fire_s;
    logic                  out_fire_s;
    logic                  wr_done_s;
    logic                  rd_done_s;
    logic [1:0]            full_next_s;
    logic [6:0]            wr_addr_s;
    logic [6:0]            rd_addr_s;

    // Handshakes, bank addressing and next-state full flags; both completions may land in one cycle.
    always_comb begin
        in_ready    = ~full_r[wr_bank_r];
        out_valid   = full_r[rd_bank_r];
        in_fire_s   = in_valid & ~full_r[wr_bank_r];
        out_fire_s  = out_ready & full_r[rd_bank_r];
        wr_done_s   = in_fire_s & (wr_count_r == 6'd63);
        rd_done_s   = out_fire_s & (rd_count_r == 6'd63);
        wr_addr_s   = {wr_bank_r, zz_to_raster(wr_count_r)};
        rd_addr_s   = {rd_bank_r, rd_count_r};
        full_next_s[0] = (full_r[0] | (wr_done_s & ~wr_bank_r)) & ~(rd_done_s & ~rd_bank_r);
        full_next_s[1] = (full_r[1] | (wr_done_s &  wr_bank_r)) & ~(rd_done_s &  rd_bank_r);
        out_data    = mem_r[rd_addr_s];
        out_index   = rd_count_r;
        out_last    = full_r[rd_bank_r] & (rd_count_r == 6'd63);
    end

    // Bank storage write port; contents are intentionally left unreset.
    always_ff @(posedge clock) begin
        if (in_fire_s) begin
            mem_r[wr_addr_s] <= in_data;
        end
    end

    // Write/read counters, bank selects and full flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_count_r <= 6'd0;
            rd_count_r <= 6'd0;
            wr_bank_r  <= 1'b0;
            rd_bank_r  <= 1'b0;
            full_r     <= 2'b00;
        end else begin
            full_r <= full_next_s;
            if (in_fire_s) begin
                wr_count_r <= wr_count_r + 6'd1;
            end
            if (wr_done_s) begin
                wr_bank_r <= ~wr_bank_r;
            end
            if (out_fire_s) begin
                rd_count_r <= rd_count_r + 6'd1;
            end
            if (rd_done_s) begin
                rd_bank_r <= ~rd_bank_r;
            end
        end
    end

endmodule

// File: tb/tb_zig_zag_reorder_buffer.sv
// Self-checking bench for zig_zag_reorder_buffer: directed scenarios plus a randomized
// run, all compared against a block-level queue model of the reorder behaviour.
module tb_zig_zag_reorder_buffer;

    logic        clock;
    logic        reset;
    logic [11:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] out_data;
    logic [5:0]  out_index;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    zig_zag_reorder_buffer #(.DATA_WIDTH(12)) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_in     = 0;
    int          n_out    = 0;
    int          zz [64];
    logic [11:0] seen [64];
    logic [11:0] in_buf [$];
    logic [11:0] exp_data [$];
    logic [5:0]  exp_idx [$];
    logic        stall_prev = 1'b0;
    logic [11:0] prev_data;
    logic [5:0]  prev_index;
    logic        prev_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against model at negedge, advance model.
    task automatic cycle(input logic v, input logic [11:0] d, input logic r);
        int          nfull;
        logic        exp_ir;
        logic        exp_ov;
        logic [11:0] blk [64];
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(negedge clock);
        nfull  = (exp_data.size() + 63) / 64;
        exp_ir = (nfull < 2);
        exp_ov = (nfull > 0);
        check("in_ready", 32'(in_ready), 32'(exp_ir));
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check("out_data", 32'(out_data), 32'(exp_data[0]));
            check("out_index", 32'(out_index), 32'(exp_idx[0]));
            check("out_last", 32'(out_last), 32'(exp_idx[0] == 6'd63));
        end else begin
            check("out_last_idle", 32'(out_last), 32'd0);
        end
        if (stall_prev) begin
            check("stall_data", 32'(out_data), 32'(prev_data));
            check("stall_index", 32'(out_index), 32'(prev_index));
            check("stall_last", 32'(out_last), 32'(prev_last));
        end
        stall_prev = exp_ov && !r;
        prev_data  = out_data;
        prev_index = out_index;
        prev_last  = out_last;
        if (exp_ov && r) begin
            seen[exp_idx[0]] = out_data;
            n_out++;
            void'(exp_data.pop_front());
            void'(exp_idx.pop_front());
        end
        if (v && exp_ir) begin
            in_buf.push_back(d);
            n_in++;
            if (in_buf.size() == 64) begin
                for (int k = 0; k < 64; k++) blk[zz[k]] = in_buf[k];
                for (int i = 0; i < 64; i++) begin
                    exp_data.push_back(blk[i]);
                    exp_idx.push_back(6'(i));
                end
                in_buf.delete();
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_index", 32'(out_index), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        @(negedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_data.delete();
        exp_idx.delete();
        in_buf.delete();
        stall_prev = 1'b0;
        #1;
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic drain(input int limit);
        int guard = 0;
        while (exp_data.size() != 0 && guard < limit) begin
            cycle(1'b0, 12'd0, 1'b1);
            guard++;
        end
        check("drain_timeout", 32'(exp_data.size()), 32'd0);
    endtask

    initial begin
        int k;
        int base;
        int guard;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 12'd0;
        out_ready = 1'b0;

        // Zig-zag table from the diagonal walk of an 8x8 block.
        k = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zz[k] = r * 8 + (s - r);
                    k++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
                    zz[k] = r * 8 + (s - r);
                    k++;
                end
            end
        end

        do_reset();

        // Identity data: data equals zig-zag position.
        for (int i = 0; i < 64; i++) cycle(1'b1, 12'(i), 1'b1);
        drain(200);
        check("idx2_data", 32'(seen[2]), 32'd5);
        check("idx8_data", 32'(seen[8]), 32'd2);
        check("idx19_data", 32'(seen[19]), 32'd17);
        check("idx63_data", 32'(seen[63]), 32'd63);

        // Three back-to-back blocks at full rate.
        base = n_out;
        for (int i = 0; i < 192; i++) cycle(1'b1, 12'($urandom_range(0, 4095)), 1'b1);
        for (int i = 0; i < 64; i++) cycle(1'b0, 12'd0, 1'b1);
        check("b2b_outputs", 32'(n_out - base), 32'd192);

        // Backpressure: both banks fill, then one drains.
        base = n_in;
        for (int i = 0; i < 132; i++) cycle(1'b1, 12'($urandom_range(0, 4095)), 1'b0);
        check("bp_accepted", 32'(n_in - base), 32'd128);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 64; i++) cycle(1'b0, 12'd0, 1'b1);
        check("bp_in_ready_back", 32'(in_ready), 32'd1);
        drain(200);

        // Mid-block reset then a constant block.
        for (int i = 0; i < 30; i++) cycle(1'b1, 12'($urandom_range(0, 4095)), 1'b1);
        do_reset();
        base = n_out;
        for (int i = 0; i < 64; i++) cycle(1'b1, 12'h5A5, 1'b1);
        drain(200);
        for (int i = 0; i < 8; i++) cycle(1'b0, 12'd0, 1'b1);
        check("abort_outputs", 32'(n_out - base), 32'd64);
        for (int i = 0; i < 64; i += 9) check("abort_value", 32'(seen[i]), 32'h5A5);

        // Randomized handshakes over 200 blocks.
        base  = n_in;
        guard = 0;
        while (n_in - base < 12800 && guard < 60000) begin
            cycle(($urandom_range(0, 3) != 0), 12'($urandom_range(0, 4095)), ($urandom_range(0, 2) != 0));
            guard++;
        end
        check("rand_inputs", 32'(n_in - base), 32'd12800);
        drain(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
